// File: rtl/hs_tx.sv
// rtl/hs_tx.sv - source side of a four-phase req/ack clock-domain-crossing handshake
module hs_tx #(
    parameter int DATA_W     = 8,
    parameter int SYNC_DEPTH = 2,
    parameter int TIMEOUT    = 0,
    parameter int CNT_W      = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_req,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_ack,
    output logic              o_done,
    output logic              o_err,
    output logic [CNT_W-1:0]  o_count
);

    // Wait counter is wide enough to reach TIMEOUT and then saturates.
    localparam int WAIT_W = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_REL
    } state_t;

    state_t                r_state;
    logic [SYNC_DEPTH-1:0] r_sync;
    logic [WAIT_W-1:0]     r_wait;
    logic [WAIT_W-1:0]     w_wait_inc;
    logic                  w_ack_s;
    logic                  w_to_hit;

    assign w_ack_s    = r_sync[SYNC_DEPTH-1];
    assign o_ready    = (r_state == ST_IDLE) && !i_rst;
    assign w_wait_inc = (r_wait == {WAIT_W{1'b1}}) ? r_wait : r_wait + 1'b1;
    assign w_to_hit   = (TIMEOUT != 0) && (w_wait_inc >= WAIT_W'(TIMEOUT));

    // i_ack is asynchronous; only the last stage of this chain is used.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_DEPTH-2:0], i_ack};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_wait  <= '0;
            o_req   <= 1'b0;
            o_data  <= '0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
            o_count <= '0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_valid && o_ready) begin
                        o_data  <= i_data;
                        o_req   <= 1'b1;
                        r_wait  <= '0;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_ack_s) begin
                        o_req   <= 1'b0;
                        r_wait  <= '0;
                        r_state <= ST_REL;
                    end else begin
                        r_wait <= w_wait_inc;
                        if (w_to_hit) begin
                            o_err <= 1'b1;
                        end
                    end
                end
                ST_REL: begin
                    if (!w_ack_s) begin
                        o_done  <= 1'b1;
                        o_count <= o_count + 1'b1;
                        r_wait  <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_wait <= w_wait_inc;
                        if (w_to_hit) begin
                            o_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hs_tx.sv
// tb/tb_hs_tx.sv - directed self-checking bench for hs_tx
module tb_hs_tx;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        ready;
    logic [7:0]  data_in;
    logic        req;
    logic [7:0]  data_out;
    logic        ack;
    logic        done;
    logic        err;
    logic [15:0] count;

    logic        loop_en;
    logic        man_ack;
    int          n_total;
    int          n_bad;

    assign ack = loop_en ? req : man_ack;

    hs_tx #(
        .DATA_W    (8),
        .SYNC_DEPTH(2),
        .TIMEOUT   (10),
        .CNT_W     (16)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_valid(valid),
        .o_ready(ready),
        .i_data (data_in),
        .o_req  (req),
        .o_data (data_out),
        .i_ack  (ack),
        .o_done (done),
        .o_err  (err),
        .o_count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst     = 1'b1;
        valid   = 1'b0;
        data_in = 8'h00;
        loop_en = 1'b0;
        man_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        valid   = 1'b0;
        data_in = 8'h00;
        loop_en = 1'b0;
        man_ack = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_in_rst got=%b want=0", ready); end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_total++;
            if (req !== 1'b0) begin n_bad++; $display("FAIL reset_req k=%0d got=%b want=0", k, req); end
            n_total++;
            if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready k=%0d got=%b want=1", k, ready); end
            n_total++;
            if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data k=%0d got=%h want=00", k, data_out); end
            n_total++;
            if (count !== 16'd0) begin n_bad++; $display("FAIL reset_count k=%0d got=%0d want=0", k, count); end
            n_total++;
            if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err k=%0d got=%b want=0", k, err); end
            n_total++;
            if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done k=%0d got=%b want=0", k, done); end
        end
    endtask

    task automatic test_loopback();
        do_reset();
        loop_en = 1'b1;
        data_in = 8'hA5;
        valid   = 1'b1;
        @(negedge clk);
        valid   = 1'b0;
        data_in = 8'h3C;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            n_total++;
            if (req !== (k < 3)) begin n_bad++; $display("FAIL loop_req k=%0d got=%b want=%b", k, req, (k < 3)); end
            n_total++;
            if (done !== (k == 6)) begin n_bad++; $display("FAIL loop_done k=%0d got=%b want=%b", k, done, (k == 6)); end
            n_total++;
            if (ready !== (k >= 6)) begin n_bad++; $display("FAIL loop_ready k=%0d got=%b want=%b", k, ready, (k >= 6)); end
            n_total++;
            if (data_out !== 8'hA5) begin n_bad++; $display("FAIL loop_data k=%0d got=%h want=a5", k, data_out); end
        end
        n_total++;
        if (count !== 16'd1) begin n_bad++; $display("FAIL loop_count got=%0d want=1", count); end
        loop_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0]  exp_data;
        logic [15:0] exp_count;
        do_reset();
        loop_en = 1'b1;
        data_in = 8'h01;
        valid   = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 21; k++) begin
            if (k > 0) @(negedge clk);
            exp_data  = 8'(1 + k / 7);
            exp_count = 16'((k + 1) / 7);
            n_total++;
            if (req !== ((k % 7) < 3)) begin n_bad++; $display("FAIL b2b_req k=%0d got=%b want=%b", k, req, ((k % 7) < 3)); end
            n_total++;
            if (ready !== ((k % 7) == 6)) begin n_bad++; $display("FAIL b2b_ready k=%0d got=%b want=%b", k, ready, ((k % 7) == 6)); end
            n_total++;
            if (done !== ((k % 7) == 6)) begin n_bad++; $display("FAIL b2b_done k=%0d got=%b want=%b", k, done, ((k % 7) == 6)); end
            n_total++;
            if (data_out !== exp_data) begin n_bad++; $display("FAIL b2b_data k=%0d got=%h want=%h", k, data_out, exp_data); end
            n_total++;
            if (count !== exp_count) begin n_bad++; $display("FAIL b2b_count k=%0d got=%0d want=%0d", k, count, exp_count); end
            if ((k % 7) == 6) data_in = 8'(k / 7 + 2);
            if (k == 20) valid = 1'b0;
        end
        @(negedge clk);
        n_total++;
        if (req !== 1'b0) begin n_bad++; $display("FAIL b2b_no_fourth got=%b want=0", req); end
        loop_en = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        data_in = 8'hC3;
        valid   = 1'b1;
        @(negedge clk);
        valid   = 1'b0;
        data_in = 8'hFF;
        for (int k = 0; k < 25; k++) begin
            if (k > 0) @(negedge clk);
            n_total++;
            if (err !== (k >= 10)) begin n_bad++; $display("FAIL to_err k=%0d got=%b want=%b", k, err, (k >= 10)); end
            n_total++;
            if (req !== (k < 17)) begin n_bad++; $display("FAIL to_req k=%0d got=%b want=%b", k, req, (k < 17)); end
            n_total++;
            if (done !== (k == 23)) begin n_bad++; $display("FAIL to_done k=%0d got=%b want=%b", k, done, (k == 23)); end
            n_total++;
            if (data_out !== 8'hC3) begin n_bad++; $display("FAIL to_data k=%0d got=%h want=c3", k, data_out); end
            if (k == 14) man_ack = 1'b1;
            if (k == 20) man_ack = 1'b0;
        end
        n_total++;
        if (count !== 16'd1) begin n_bad++; $display("FAIL to_count got=%0d want=1", count); end
    endtask

    task automatic test_reset_mid();
        data_in = 8'h5A;
        valid   = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        n_total++;
        if (req !== 1'b1 || data_out !== 8'h5A) begin n_bad++; $display("FAIL mid_pre req=%b data=%h want req=1 data=5a", req, data_out); end
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if (req !== 1'b0) begin n_bad++; $display("FAIL mid_req got=%b want=0", req); end
        n_total++;
        if (data_out !== 8'h00) begin n_bad++; $display("FAIL mid_data got=%h want=00", data_out); end
        n_total++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL mid_err got=%b want=0", err); end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_total++;
            if (ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready k=%0d got=%b want=1", k, ready); end
            n_total++;
            if (done !== 1'b0) begin n_bad++; $display("FAIL mid_done k=%0d got=%b want=0", k, done); end
            n_total++;
            if (count !== 16'd0) begin n_bad++; $display("FAIL mid_count k=%0d got=%0d want=0", k, count); end
        end
    endtask

    task automatic test_slow_dest();
        do_reset();
        data_in = 8'h96;
        valid   = 1'b1;
        @(negedge clk);
        valid   = 1'b0;
        data_in = 8'h00;
        for (int k = 0; k < 42; k++) begin
            if (k > 0) @(negedge clk);
            n_total++;
            if (req !== (k < 22)) begin n_bad++; $display("FAIL slow_req k=%0d got=%b want=%b", k, req, (k < 22)); end
            n_total++;
            if (done !== (k == 39)) begin n_bad++; $display("FAIL slow_done k=%0d got=%b want=%b", k, done, (k == 39)); end
            n_total++;
            if (ready !== (k >= 39)) begin n_bad++; $display("FAIL slow_ready k=%0d got=%b want=%b", k, ready, (k >= 39)); end
            n_total++;
            if (data_out !== 8'h96) begin n_bad++; $display("FAIL slow_data k=%0d got=%h want=96", k, data_out); end
            n_total++;
            if (err !== (k >= 10)) begin n_bad++; $display("FAIL slow_err k=%0d got=%b want=%b", k, err, (k >= 10)); end
            if (k == 19) man_ack = 1'b1;
            if (k == 36) man_ack = 1'b0;
        end
        n_total++;
        if (count !== 16'd1) begin n_bad++; $display("FAIL slow_count got=%0d want=1", count); end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b1;
        valid   = 1'b0;
        data_in = 8'h00;
        loop_en = 1'b0;
        man_ack = 1'b0;
        test_reset();
        test_loopback();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_slow_dest();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/hs_tx.md
Name: hs_tx

Overview:
- Source-side (transmitter) end of a four-phase req/ack clock-domain-crossing handshake.
- Accepts a data word in the local `i_clk` domain over a valid/ready interface, then holds it stable on `o_data` while it drives `o_req`.
- Waits for the destination's asynchronous `i_ack`, brought into `i_clk` through an internal SYNC_DEPTH flip-flop chain, to complete the req-high/ack-high/req-low/ack-low cycle.
- Pairs with a destination-side receiver that samples `o_data` once its synchronised `o_req` is high.

Parameters:
- DATA_W, 8, width of the transferred word.
- SYNC_DEPTH, 2, number of flip-flops in the `i_ack` synchroniser chain (≥2).
- TIMEOUT, 0, cycles allowed per wait phase before `o_err` sets; 0 disables timeout checking.
- CNT_W, 16, width of the completed-transfer counter.

Ports:
- i_clk  input  1  sole clock.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  source has a word on `i_data`.
- o_ready  output  1  block can accept a word.
- i_data  input  DATA_W  word to transfer.
- o_req  output  1  handshake request, registered, to destination domain.
- o_data  output  DATA_W  held word, registered, stable whenever `o_req`=1 and until ack low is seen.
- i_ack  input  1  asynchronous acknowledge from destination domain.
- o_done  output  1  one-cycle pulse on handshake completion.
- o_err  output  1  sticky timeout flag.
- o_count  output  CNT_W  completed transfers, wraps modulo 2^CNT_W.

Behaviour:
- Interface (decided): one clock `i_clk`; reset `i_rst` is synchronous and active-high.
- Reset values: state=IDLE, `o_req`=0, `o_data`=0, sync chain all 0, `o_done`=0, `o_err`=0, `o_count`=0, wait counter=0.
- Synchroniser: `s[0]<=i_ack`, `s[k]<=s[k-1]`, `ack_s=s[SYNC_DEPTH-1]`. No other logic reads `i_ack` directly.
- `o_ready` = (state==IDLE) && !`i_rst`, decoded from registered state.
- FSM states: IDLE, REQ, REL.
  - IDLE: if `i_valid`&&`o_ready`, capture `o_data<=i_data`, set `o_req<=1`, go to REQ. Otherwise hold.
  - REQ: if `ack_s`=1, set `o_req<=0`, go to REL.
  - REL: if `ack_s`=0, go to IDLE, pulse `o_done`=1 for one cycle, increment `o_count`.
- `o_data` changes only on accept in IDLE. It never changes in REQ or REL.
- Inputs ignored outside IDLE: `i_valid`/`i_data`.
- Loopback latency (`i_ack` wired to `o_req`), accept at edge N:
  - `o_req` high after N.
  - REL after N+SYNC_DEPTH+1.
  - IDLE and `o_done` after N+2·SYNC_DEPTH+2.
  - Next accept possible at edge N+2·SYNC_DEPTH+3 (7-cycle period at depth 2).
- Wait counter:
  - Cleared on every state change; increments each cycle in REQ or REL, saturating.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT, set `o_err<=1`. The sticky flag clears only on reset.
  - The FSM keeps waiting; it never abandons a handshake.
- `ack_s` high while in IDLE (destination misbehaving): ignored. A new accept still asserts `o_req`; REQ then completes on the next cycle `ack_s` is seen high.
- Reset mid-handshake: immediate return to reset values, `o_req` drops. The destination must be reset together with this block.
- `o_count` wraps from 2^CNT_W−1 to 0 without flag.

Test Plan:
- Reset and idle:
  - Stimulus: assert `i_rst` 3 cycles, `i_valid`=0, `i_ack`=0.
  - Required: `o_req`=0, `o_ready`=1 after reset released, `o_data`=0, `o_count`=0, `o_err`=0, `o_done` never high.
- Loopback single transfer:
  - Stimulus: `i_ack`=`o_req`, SYNC_DEPTH=2, one-cycle `i_valid` with `i_data`=0xA5 accepted at edge N.
  - Required: `o_data`=0xA5 from N to end of handshake; `o_req` high after N, low after N+3; `o_done` pulse after N+6; `o_count`=1.
- Back-to-back:
  - Stimulus: `i_valid` held high with 0x01, 0x02, 0x03 advancing on each accept.
  - Required: accepts 7 cycles apart; 0x01, 0x02, 0x03 each stable through their REQ/REL; `o_ready`=0 between accepts; `o_count`=3.
- Slow destination:
  - Stimulus: `i_ack` raised 20 cycles after `o_req`, dropped 15 cycles after `o_req` falls.
  - Required: `o_req` stays high until 3 cycles after `i_ack` rises; `o_done` 3 cycles after `i_ack` falls; `o_data` unchanged throughout.
- Timeout:
  - Stimulus: TIMEOUT=10, `i_ack` held 0 after accept.
  - Required: `o_err`=1 after 10 cycles in REQ, `o_req` stays 1. Later `i_ack` toggling completes the handshake normally with `o_err` still 1.
- Reset mid-operation:
  - Stimulus: assert `i_rst` while in REQ with `o_data`=0x5A.
  - Required: next cycle `o_req`=0, `o_data`=0, `o_ready`=1 after release, no `o_done`, `o_count` unchanged at 0.
